// File: rtl/gpu_pll_sup_pkg.sv
// Shared types and widths for the GPU PLL lock supervisor.
package gpu_pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int RETRY_W = 4;
  localparam int EVT_W   = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gpu_sync_2ff.sv
// Generic two-flop synchronizer, clears to 0 on reset.
module gpu_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/gpu_pll_lock_supervisor.sv
// PLL reset sequencer and lock supervisor; releases sys_rst_n after a stable lock window.
// Optional relock event counter enabled by defining GPU_PLL_SUP_EVENT_CNT_EN.
//
// state     | meaning
// RESET_PLL | pll_rst held high for RST_CYCLES
// WAIT_LOCK | pll_rst low, waiting for synced lock or timeout
// STABLE    | lock seen, counting the stable window
// RUN       | downstream released, watching for lock loss
// FAIL      | retries exhausted, parked until soft/hard reset
module gpu_pll_lock_supervisor
  import gpu_pll_sup_pkg::*;
#(
  parameter int RST_CYCLES          = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 4
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               soft_reset_req,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_count,
  output logic [EVT_W-1:0]   relock_events
);

  localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES)) + 1;

  logic               w_locked_s;
  state_t             r_state;
  state_t             w_nxt_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_nxt_cnt;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_nxt_retry;
  logic [RETRY_W-1:0] w_retry_inc;
  logic               r_pll_rst;
  logic               r_sys_rst_n;
  logic               r_ready;
  logic               r_fail;

  gpu_sync_2ff #(.WIDTH(1)) u_lock_sync (
    .i_clk   (refclk),
    .i_rst_n (rst_n),
    .i_d     (pll_locked),
    .o_q     (w_locked_s)
  );

  assign w_retry_inc = r_retry + 1'b1;

  // One counter serves all three timed states; it is cleared on every state change.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt + 1'b1;
    w_nxt_retry = r_retry;
    if (soft_reset_req) begin
      w_nxt_state = RESET_PLL;
      w_nxt_cnt   = '0;
      w_nxt_retry = '0;
    end else begin
      case (r_state)
        RESET_PLL: begin
          if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
            w_nxt_state = WAIT_LOCK;
            w_nxt_cnt   = '0;
          end
        end
        WAIT_LOCK: begin
          if (w_locked_s) begin
            w_nxt_state = STABLE;
            w_nxt_cnt   = '0;
          end else if (r_cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
            w_nxt_retry = w_retry_inc;
            w_nxt_state = (w_retry_inc == RETRY_W'(MAX_RETRIES)) ? FAIL : RESET_PLL;
            w_nxt_cnt   = '0;
          end
        end
        STABLE: begin
          if (!w_locked_s) begin
            w_nxt_state = WAIT_LOCK;
            w_nxt_cnt   = '0;
          end else if (r_cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
            w_nxt_state = RUN;
            w_nxt_cnt   = '0;
            w_nxt_retry = '0;
          end
        end
        RUN: begin
          w_nxt_cnt = '0;
          if (!w_locked_s) w_nxt_state = RESET_PLL;
        end
        FAIL: begin
          w_nxt_cnt = '0;
        end
        default: begin
          w_nxt_state = RESET_PLL;
          w_nxt_cnt   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they move on the same edge as the state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RESET_PLL;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_retry     <= w_nxt_retry;
      r_pll_rst   <= (w_nxt_state == RESET_PLL) || (w_nxt_state == FAIL);
      r_sys_rst_n <= (w_nxt_state == RUN);
      r_ready     <= (w_nxt_state == RUN);
      r_fail      <= (w_nxt_state == FAIL);
    end
  end

  assign pll_rst     = r_pll_rst;
  assign sys_rst_n   = r_sys_rst_n;
  assign ready       = r_ready;
  assign fail        = r_fail;
  assign retry_count = r_retry;

`ifdef GPU_PLL_SUP_EVENT_CNT_EN
  logic             w_lock_loss;
  logic [EVT_W-1:0] r_relock;

  // A lock drop in RUN counts once even if a soft reset lands on the same cycle.
  assign w_lock_loss = (r_state == RUN) && !w_locked_s;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_relock <= '0;
    end else if (w_lock_loss && (r_relock != {EVT_W{1'b1}})) begin
      r_relock <= r_relock + 1'b1;
    end
  end

  assign relock_events = r_relock;
`else
  assign relock_events = '0;
`endif

endmodule

// File: tb/tb_gpu_pll_lock_supervisor.sv
// Directed bench for gpu_pll_lock_supervisor; expected relock counts follow GPU_PLL_SUP_EVENT_CNT_EN.
module tb_gpu_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst_n  = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_reset_req = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_count;
  logic [7:0] relock_events;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  gpu_pll_lock_supervisor #(
    .RST_CYCLES          (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .MAX_RETRIES         (2)
  ) dut (
    .refclk         (refclk),
    .rst_n          (rst_n),
    .pll_locked     (pll_locked),
    .soft_reset_req (soft_reset_req),
    .pll_rst        (pll_rst),
    .sys_rst_n      (sys_rst_n),
    .ready          (ready),
    .fail           (fail),
    .retry_count    (retry_count),
    .relock_events  (relock_events)
  );

  always #5 refclk = ~refclk;

  function automatic int evt_exp(input int n);
`ifdef GPU_PLL_SUP_EVENT_CNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic step();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int k);
    while (cyc < k) step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    pll_locked = 1'b0;
    soft_reset_req = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge refclk);
    @(negedge refclk);
    rst_n = 1'b1;
    cyc = -1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_pll_rst"},   pll_rst, 1);
    check_eq({tag, "_sys_rst_n"}, sys_rst_n, 0);
    check_eq({tag, "_ready"},     ready, 0);
    check_eq({tag, "_fail"},      fail, 0);
    check_eq({tag, "_retry"},     retry_count, 0);
    check_eq({tag, "_relock"},    relock_events, 0);
  endtask

  task automatic wait_ready(input int bound);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    check_eq("wait_ready", ready, 1);
  endtask

  initial begin
    #2;
    apply_reset();
    check_reset_vals("por");
    release_reset();

    // Clean lock, then lock loss in RUN
    goto(2);  check_eq("clean_pll_rst_c2", pll_rst, 1);
    goto(3);  check_eq("clean_pll_rst_c3", pll_rst, 0);
    goto(10); pll_locked = 1'b1;
    goto(20); check_eq("clean_sys_rst_c20", sys_rst_n, 0);
    check_eq("clean_ready_c20", ready, 0);
    goto(21); check_eq("clean_sys_rst_c21", sys_rst_n, 1);
    check_eq("clean_ready_c21", ready, 1);
    check_eq("clean_retry", retry_count, 0);
    goto(30); pll_locked = 1'b0;
    goto(32); check_eq("loss_sys_rst_c32", sys_rst_n, 1);
    goto(33); check_eq("loss_sys_rst_c33", sys_rst_n, 0);
    check_eq("loss_ready_c33", ready, 0);
    check_eq("loss_pll_rst_c33", pll_rst, 1);
    check_eq("loss_relock", relock_events, evt_exp(1));
    goto(36); check_eq("loss_pll_rst_c36", pll_rst, 1);
    goto(37); check_eq("loss_pll_rst_c37", pll_rst, 0);
    goto(40); pll_locked = 1'b1;
    goto(50); check_eq("relock_ready_c50", ready, 0);
    goto(51); check_eq("relock_ready_c51", ready, 1);

    // Glitch during STABLE
    apply_reset();
    check_reset_vals("rst2");
    release_reset();
    goto(10); pll_locked = 1'b1;
    goto(16); pll_locked = 1'b0;
    goto(17); pll_locked = 1'b1;
    goto(21); check_eq("glitch_sys_rst_c21", sys_rst_n, 0);
    goto(27); check_eq("glitch_sys_rst_c27", sys_rst_n, 0);
    goto(28); check_eq("glitch_sys_rst_c28", sys_rst_n, 1);
    check_eq("glitch_ready_c28", ready, 1);

    // Never locks, then recovery from FAIL
    apply_reset();
    release_reset();
    goto(34); check_eq("nolock_retry_c34", retry_count, 0);
    goto(35); check_eq("nolock_retry_c35", retry_count, 1);
    check_eq("nolock_pll_rst_c35", pll_rst, 1);
    goto(70); check_eq("nolock_fail_c70", fail, 0);
    goto(71); check_eq("nolock_fail_c71", fail, 1);
    check_eq("nolock_retry_c71", retry_count, 2);
    check_eq("nolock_pll_rst_c71", pll_rst, 1);
    check_eq("nolock_sys_rst_c71", sys_rst_n, 0);
    goto(80); check_eq("nolock_fail_c80", fail, 1);
    soft_reset_req = 1'b1;
    goto(81); soft_reset_req = 1'b0;
    check_eq("recover_fail", fail, 0);
    check_eq("recover_retry", retry_count, 0);
    check_eq("recover_pll_rst", pll_rst, 1);
    pll_locked = 1'b1;
    goto(93); check_eq("recover_ready_c93", ready, 0);
    goto(94); check_eq("recover_ready_c94", ready, 1);
    check_eq("recover_relock", relock_events, 0);

    // Relock event saturation
    for (int i = 0; i < 260; i++) begin
      wait_ready(40);
      pll_locked = 1'b0;
      repeat (4) step();
      pll_locked = 1'b1;
      if (i == 99 || i == 254 || i == 259)
        check_eq("sat_relock", relock_events, evt_exp(i + 1));
    end
    wait_ready(40);

    // Soft reset keeps events; hard reset mid-STABLE clears everything at once
    soft_reset_req = 1'b1;
    step();
    soft_reset_req = 1'b0;
    check_eq("soft_pll_rst", pll_rst, 1);
    check_eq("soft_relock_kept", relock_events, evt_exp(260));
    repeat (7) step();
    check_eq("stable_pll_rst", pll_rst, 0);
    check_eq("stable_ready", ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
